axi4_rd_to_axi_stream: RTL and testbench
========================================

# axi4_rd_to_axi_stream

Read-side counterpart of the stream-to-AXI4 write path. Accepts a command packet on an AXI-Stream slave carrying a 64-bit {addr, length} header and issues AXI4 INCR read bursts (split at MAX_BURST beats, one burst outstanding). It returns the read data as a single AXI-Stream packet with tlast on the final beat. It sits between a DMA/command engine and an AXI4 memory slave.

## Interface
Parameters:
- DSIZE, 32, stream and AXI data width in bits; power of two, 8..1024.
- ASIZE, 32, AXI address width.
- IDSIZE, 4, AXI ID width.
- MAX_BURST, 256, maximum beats per AR burst; power of two, 1..256.

Ports:
- axi_aclk  in  1  the single clock for all logic.
- axi_aresetn  in  1  reset; asynchronous, active-low.
- cmd_tdata  in  DSIZE  header beats.
- cmd_tvalid / cmd_tlast  in  1  header beat valid / last.
- cmd_tready  out  1  header accept.
- axi_arid  out  IDSIZE  read ID; constant 0.
- axi_araddr  out  ASIZE  burst address.
- axi_arlen  out  8  burst length minus 1.
- axi_arsize  out  3  log2(DSIZE/8).
- axi_arburst  out  2  constant 2'b01 (INCR).
- axi_arvalid  out  1  AR request.
- axi_arready  in  1  AR accept.
- axi_rdata  in  DSIZE  read data.
- axi_rresp  in  2  read response.
- axi_rlast / axi_rvalid  in  1  R last / valid.
- axi_rready  out  1  R accept.
- m_tdata  out  DSIZE  output data.
- m_tvalid / m_tlast  out  1  output valid / packet last.
- m_tready  in  1  output accept.
- busy  out  1  high from header acceptance until the last output beat.
- err  out  1  sticky error; cleared only by reset.
- hdr_err  out  1  one-cycle pulse when a short header packet is dropped.

## Operation
- FIELD_LEN = ceil(64/DSIZE) header beats. Beats are concatenated first-beat-most-significant; the low 64 bits of the result give addr = [63:32] and length = [31:0]. length is the total beat count.
- FSM states:
  - IDLE/HDR: cmd_tready=1; counts beats.
  - DRAIN: discard beats after FIELD_LEN until tlast.
  - AR: arvalid=1, fields held stable.
  - DATA: rready = m_tready.
- A header beat with tlast before FIELD_LEN beats: discard the header, pulse hdr_err, stay in HDR.
- FIELD_LEN-th beat without tlast: go to DRAIN. With tlast: latch addr/length, go to AR; if length==0, return to IDLE instead, with no AR and busy not raised.
- Burst split, per burst: beats = min(remaining, MAX_BURST); arlen = beats-1; after the AR handshake, addr += beats*(DSIZE/8) and remaining -= beats. Arithmetic is 32-bit; address wraps modulo 2^ASIZE. No 4 KB boundary splitting; this is a caller obligation.
- DATA is a zero-latency passthrough: m_tdata=rdata, m_tvalid=rvalid, rready=m_tready. m_tlast=1 only on the final beat of the final burst.
- End of burst is the R beat counter reaching beats. At that point: AR if remaining>0, else IDLE.
- Error conditions, each setting err: rlast disagreeing with the beat counter, or rresp != OKAY. On error, data is still forwarded and the beat counter governs.

## Timing
- Reset: every output 0 except axi_arsize/axi_arburst constants. The FSM goes to IDLE and counters clear. A reset mid-burst abandons the AXI transaction; the system resets the slave together with this block.
- Header last beat accepted at cycle N → axi_arvalid=1 at N+1, registered.
- AR handshake at cycle M → axi_rready may assert at M+1.
- Final R beat of a non-final burst at cycle K → next axi_arvalid at K+1.
- Final beat handshake → busy=0 and cmd_tready=1 on the next cycle.
- AR fields never change while arvalid=1 and arready=0.
- Data throughput: 1 beat/cycle within a burst; 1 bubble between bursts due to the AR handshake.

## Structure
- Package axi4_rd_stream_pkg:
  - state enum (IDLE, DRAIN, AR, DATA);
  - AXI_BURST_INCR, AXI_RESP_OKAY;
  - function clog2_bytes(DSIZE).
- Sub-module axi4_rd_burst_split: holds addr/remaining and produces araddr/arlen plus a last_burst flag on each advance strobe. Top level holds the header collector, FSM and R beat counter.

## Test plan
- DSIZE=32; header 0x0000_1000, 0x0000_0004 → one AR: araddr=0x1000, arlen=3. 4 output beats, tlast on the 4th, busy drops after.
- length=600 → ARs (0x1000, 255), (0x1400, 255), (0x1800, 87). Exactly 600 beats; tlast only on beat 600; 1 bubble per burst boundary.
- m_tready random 50% with rvalid always high → rready mirrors m_tready. No beat lost or duplicated; the data sequence matches memory.
- length=0 → no arvalid, busy stays 0. Short header (tlast on beat 1) → hdr_err pulse, no AR. A 3-beat header packet → third beat drained, one AR.
- rresp=SLVERR on beat 2, and an early rlast on a separate burst → err sticks high; all beats still forwarded.
- axi_aresetn low mid-DATA → all outputs 0 asynchronously; after release, a new header completes normally.

Source files
------------

// File: rtl/axi4_rd_stream_pkg.sv
// Shared state encoding, AXI constants and helpers for the AXI4 read-to-stream bridge.
package axi4_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    AR    = 2'd2,
    DATA  = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI size encoding: log2 of the bytes carried by one data beat.
  function automatic logic [2:0] clog2_bytes(input int dsize);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == dsize) res = 3'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_rd_burst_split.sv
// Tracks the remaining transfer and presents the next INCR burst (address, length)
// together with the length and last-burst flag of the burst currently in flight.
module axi4_rd_burst_split
  import axi4_rd_stream_pkg::*;
#(
  parameter int ASIZE     = 32,
  parameter int MAX_BURST = 256,
  parameter int BYTES     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ASIZE-1:0] load_addr,
  input  logic [31:0]      load_len,
  input  logic             advance,
  output logic [ASIZE-1:0] araddr,
  output logic [7:0]       arlen,
  output logic [7:0]       cur_len,
  output logic             last_burst,
  output logic             empty
);

  logic [31:0] rem_r;
  logic [8:0]  beats_s;
  logic [31:0] next_rem_s;
  logic [31:0] step_s;

  function automatic logic [8:0] burst_beats(input logic [31:0] rem);
    if (rem > 32'(MAX_BURST)) return 9'(MAX_BURST);
    else return rem[8:0];
  endfunction

  function automatic logic [7:0] to_arlen(input logic [8:0] beats);
    if (beats == 9'd0) return 8'd0;
    else return 8'(beats - 9'd1);
  endfunction

  assign beats_s    = burst_beats(rem_r);
  assign next_rem_s = rem_r - {23'd0, beats_s};
  assign step_s     = {23'd0, beats_s} * 32'(BYTES);
  assign empty      = (rem_r == 32'd0);

  // Load a new transfer, or step past the burst the AR channel just accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr     <= {ASIZE{1'b0}};
      rem_r      <= 32'd0;
      arlen      <= 8'd0;
      cur_len    <= 8'd0;
      last_burst <= 1'b0;
    end else if (load) begin
      araddr <= load_addr;
      rem_r  <= load_len;
      arlen  <= to_arlen(burst_beats(load_len));
    end else if (advance) begin
      araddr     <= araddr + ASIZE'(step_s);
      rem_r      <= next_rem_s;
      arlen      <= to_arlen(burst_beats(next_rem_s));
      cur_len    <= arlen;
      last_burst <= (next_rem_s == 32'd0);
    end
  end

endmodule

// File: rtl/axi4_rd_to_axi_stream.sv
// Collects a {addr, length} command header, issues split AXI4 INCR reads one at a
// time and forwards the read data as a single AXI-Stream packet.
module axi4_rd_to_axi_stream
  import axi4_rd_stream_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 32,
  parameter int IDSIZE    = 4,
  parameter int MAX_BURST = 256
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [DSIZE-1:0]  cmd_tdata,
  input  logic              cmd_tvalid,
  input  logic              cmd_tlast,
  output logic              cmd_tready,
  output logic [IDSIZE-1:0] axi_arid,
  output logic [ASIZE-1:0]  axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DSIZE-1:0]  axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [DSIZE-1:0]  m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              busy,
  output logic              err,
  output logic              hdr_err
);

  localparam int FIELD_LEN = (64 + DSIZE - 1) / DSIZE;
  localparam int HW        = FIELD_LEN * DSIZE;

  state_t            state_r, state_s;
  logic [HW-1:0]     hdr_r, hdr_next_s;
  logic [3:0]        hdr_cnt_r, hdr_cnt_s;
  logic [7:0]        rcnt_r, rcnt_s;
  logic              load_s, advance_s, hdr_err_s, err_s;
  logic              cmd_hs_s, r_hs_s, burst_end_s, in_data_s;
  logic              cmd_tready_r, busy_r, arvalid_r, hdr_err_r, err_r;
  logic [7:0]        cur_len_s;
  logic              last_burst_s, empty_s;

  axi4_rd_burst_split #(
    .ASIZE    (ASIZE),
    .MAX_BURST(MAX_BURST),
    .BYTES    (DSIZE / 8)
  ) u_split (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .load      (load_s),
    .load_addr (ASIZE'(hdr_next_s[63:32])),
    .load_len  (hdr_next_s[31:0]),
    .advance   (advance_s),
    .araddr    (axi_araddr),
    .arlen     (axi_arlen),
    .cur_len   (cur_len_s),
    .last_burst(last_burst_s),
    .empty     (empty_s)
  );

  // First header beat ends up most significant after FIELD_LEN shifts.
  assign hdr_next_s  = (hdr_r << DSIZE) | HW'(cmd_tdata);
  assign cmd_hs_s    = cmd_tvalid & cmd_tready_r;
  assign in_data_s   = (state_r == DATA);
  assign r_hs_s      = in_data_s & axi_rvalid & m_tready;
  assign burst_end_s = (rcnt_r == cur_len_s);

  // Next-state, header counting, burst stepping and error detection.
  always_comb begin
    state_s   = state_r;
    hdr_cnt_s = hdr_cnt_r;
    rcnt_s    = rcnt_r;
    load_s    = 1'b0;
    advance_s = 1'b0;
    hdr_err_s = 1'b0;
    err_s     = err_r;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) begin
          if (hdr_cnt_r == 4'(FIELD_LEN - 1)) begin
            hdr_cnt_s = 4'd0;
            load_s    = 1'b1;
            if (!cmd_tlast) state_s = DRAIN;
            else if (hdr_next_s[31:0] == 32'd0) state_s = IDLE;
            else state_s = AR;
          end else if (cmd_tlast) begin
            hdr_cnt_s = 4'd0;
            hdr_err_s = 1'b1;
          end else begin
            hdr_cnt_s = hdr_cnt_r + 4'd1;
          end
        end else begin
          hdr_cnt_s = hdr_cnt_r;
        end
      end
      DRAIN: begin
        if (cmd_hs_s && cmd_tlast) state_s = empty_s ? IDLE : AR;
        else state_s = DRAIN;
      end
      AR: begin
        if (arvalid_r && axi_arready) begin
          advance_s = 1'b1;
          rcnt_s    = 8'd0;
          state_s   = DATA;
        end else begin
          state_s = AR;
        end
      end
      DATA: begin
        if (r_hs_s) begin
          if ((axi_rlast != burst_end_s) || (axi_rresp != AXI_RESP_OKAY)) err_s = 1'b1;
          else err_s = err_r;
          if (burst_end_s) begin
            rcnt_s  = 8'd0;
            state_s = last_burst_s ? IDLE : AR;
          end else begin
            rcnt_s = rcnt_r + 8'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counters and registered control outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r      <= IDLE;
      hdr_r        <= {HW{1'b0}};
      hdr_cnt_r    <= 4'd0;
      rcnt_r       <= 8'd0;
      cmd_tready_r <= 1'b0;
      busy_r       <= 1'b0;
      arvalid_r    <= 1'b0;
      hdr_err_r    <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      hdr_r        <= (cmd_hs_s && state_r == IDLE) ? hdr_next_s : hdr_r;
      hdr_cnt_r    <= hdr_cnt_s;
      rcnt_r       <= rcnt_s;
      cmd_tready_r <= (state_s == IDLE) || (state_s == DRAIN);
      busy_r       <= (state_s == AR) || (state_s == DATA);
      arvalid_r    <= (state_s == AR);
      hdr_err_r    <= hdr_err_s;
      err_r        <= err_s;
    end
  end

  assign cmd_tready  = cmd_tready_r;
  assign busy        = busy_r;
  assign err         = err_r;
  assign hdr_err     = hdr_err_r;
  assign axi_arvalid = arvalid_r;
  assign axi_arid    = {IDSIZE{1'b0}};
  assign axi_arsize  = clog2_bytes(DSIZE);
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_rready  = in_data_s & m_tready;
  assign m_tdata     = in_data_s ? axi_rdata : {DSIZE{1'b0}};
  assign m_tvalid    = in_data_s & axi_rvalid;
  assign m_tlast     = in_data_s & axi_rvalid & last_burst_s & burst_end_s;

endmodule

// File: tb/tb_axi4_rd_to_axi_stream.sv
// Randomized bench: a queue-based reference model predicts the AR bursts and the
// output data stream of each command; a behavioural memory slave serves the reads.
module tb_axi4_rd_to_axi_stream;

  localparam int DSIZE = 32, ASIZE = 32, IDSIZE = 4, MAX_BURST = 256;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn = 1'b0;
  logic [DSIZE-1:0]  cmd_tdata = '0;
  logic              cmd_tvalid = 1'b0, cmd_tlast = 1'b0, cmd_tready;
  logic [IDSIZE-1:0] axi_arid;
  logic [ASIZE-1:0]  axi_araddr;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic              axi_arvalid, axi_arready = 1'b0;
  logic [DSIZE-1:0]  axi_rdata = '0;
  logic [1:0]        axi_rresp = 2'b00;
  logic              axi_rlast = 1'b0, axi_rvalid = 1'b0, axi_rready;
  logic [DSIZE-1:0]  m_tdata;
  logic              m_tvalid, m_tlast, m_tready = 1'b0;
  logic              busy, err, hdr_err;

  always #5 axi_aclk = ~axi_aclk;

  axi4_rd_to_axi_stream #(.DSIZE(DSIZE), .ASIZE(ASIZE), .IDSIZE(IDSIZE), .MAX_BURST(MAX_BURST)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tlast(cmd_tlast), .cmd_tready(cmd_tready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .err(err), .hdr_err(hdr_err)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents: odd multiplier makes every word address map to a distinct value.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BAD_F00D;
  endfunction

  logic [33:0] cmd_q[$];     // {expect AR after this beat, tlast, data}
  logic [63:0] exp_ar_q[$];  // {araddr, 24'b0, arlen}
  logic [31:0] exp_d_q[$];

  int p_tr = 100, p_rv = 100, p_arr = 100, p_cmdv = 100;
  bit sl_act = 0, sl_early = 0, exp_arv = 0, fin_chk = 0, ar_wait = 0;
  logic [31:0] sl_addr = '0;
  logic [39:0] ar_hold = '0;
  int sl_len = 0, sl_idx = 0, burst_no = 0, early_burst = -1, r_beats = 0, slverr_beat = -1;
  int cyc = 0, m_beats = 0, ar_seen = 0, hdr_err_seen = 0, busy_seen = 0, first_m = -1, last_m = -1;

  task automatic queue_cmd(input logic [31:0] a, input logic [31:0] len, input int extra);
    logic [31:0] rem, cur, b;
    cmd_q.push_back({1'b0, 1'b0, a});
    cmd_q.push_back({(extra == 0) && (len != 0), extra == 0, len});
    for (int k = 0; k < extra; k++) cmd_q.push_back({(k == extra - 1) && (len != 0), k == extra - 1, $urandom()});
    rem = len;
    cur = a;
    while (rem > 0) begin
      b = (rem > MAX_BURST) ? MAX_BURST : rem;
      exp_ar_q.push_back({cur, 24'd0, 8'(b - 1)});
      cur += b * 4;
      rem -= b;
    end
    for (int j = 0; j < int'(len); j++) exp_d_q.push_back(mem_word(a + 32'(j * 4)));
  endtask

  task automatic idle_inputs();
    cmd_tvalid = 1'b0; cmd_tdata = '0; cmd_tlast = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b0; axi_rdata = '0; axi_rlast = 1'b0; axi_rresp = 2'b00; m_tready = 1'b0;
  endtask

  task automatic step();
    @(negedge axi_aclk);
    if (cmd_q.size() > 0) begin
      cmd_tvalid = int'($urandom_range(99)) < p_cmdv;
      cmd_tdata  = cmd_q[0][31:0];
      cmd_tlast  = cmd_q[0][32];
    end else begin
      cmd_tvalid = 1'b0; cmd_tdata = '0; cmd_tlast = 1'b0;
    end
    axi_arready = int'($urandom_range(99)) < p_arr;
    if (sl_act) begin
      axi_rvalid = int'($urandom_range(99)) < p_rv;
      axi_rdata  = mem_word(sl_addr + 32'(sl_idx * 4));
      axi_rlast  = sl_early ? (sl_idx == 0) : (sl_idx == sl_len - 1);
      axi_rresp  = (r_beats == slverr_beat) ? 2'b10 : 2'b00;
    end else begin
      axi_rvalid = 1'b0; axi_rdata = '0; axi_rlast = 1'b0; axi_rresp = 2'b00;
    end
    m_tready = int'($urandom_range(99)) < p_tr;
    #1;
    cyc++;
    if (fin_chk) begin
      check("busy_after_last", busy, 0);
      check("cmd_tready_after_last", cmd_tready, 1);
      fin_chk = 0;
    end
    if (exp_arv) begin
      check("arvalid_latency", axi_arvalid, 1);
      exp_arv = 0;
    end
    if (sl_act) begin
      check("rready_mirror", axi_rready, m_tready);
      check("tvalid_pass", m_tvalid, axi_rvalid);
    end else begin
      check("rready_idle", axi_rready, 0);
    end
    if (ar_wait && axi_arvalid) check("ar_stable", {axi_araddr, axi_arlen}, ar_hold);
    ar_wait = axi_arvalid && !axi_arready;
    ar_hold = {axi_araddr, axi_arlen};
    if (axi_rvalid && axi_rready) begin
      r_beats++;
      sl_idx++;
      if (sl_idx == sl_len) sl_act = 0;
    end
    if (m_tvalid && m_tready) begin
      check("m_beat_expected", exp_d_q.size() > 0, 1);
      if (exp_d_q.size() > 0) begin
        check("m_tdata", m_tdata, exp_d_q[0]);
        check("m_tlast", m_tlast, exp_d_q.size() == 1);
        if (exp_d_q.size() == 1) fin_chk = 1;
        void'(exp_d_q.pop_front());
      end
      m_beats++;
      if (first_m < 0) first_m = cyc;
      last_m = cyc;
    end
    if (axi_arvalid && axi_arready) begin
      ar_seen++;
      check("ar_expected", exp_ar_q.size() > 0, 1);
      if (exp_ar_q.size() > 0) begin
        check("ar_fields", {axi_araddr, 24'd0, axi_arlen}, exp_ar_q[0]);
        void'(exp_ar_q.pop_front());
      end
      sl_act   = 1;
      sl_addr  = axi_araddr;
      sl_len   = int'(axi_arlen) + 1;
      sl_idx   = 0;
      sl_early = (burst_no == early_burst);
      burst_no++;
    end
    if (cmd_tvalid && cmd_tready) begin
      if (cmd_q[0][33]) exp_arv = 1;
      void'(cmd_q.pop_front());
    end
    if (hdr_err) hdr_err_seen++;
    if (busy) busy_seen++;
  endtask

  task automatic run_done(input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() > 0 || exp_ar_q.size() > 0 || exp_d_q.size() > 0 || sl_act) && n < budget) begin
      step();
      n++;
    end
    check("done_in_budget", n < budget, 1);
    if (n >= budget) begin
      cmd_q.delete(); exp_ar_q.delete(); exp_d_q.delete(); sl_act = 0;
    end
    repeat (3) step();
  endtask

  task automatic reset_checks();
    check("rst_cmd_tready", cmd_tready, 0);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_araddr", axi_araddr, 0);
    check("rst_arlen", axi_arlen, 0);
    check("rst_arid", axi_arid, 0);
    check("rst_arsize", axi_arsize, 3'd2);
    check("rst_arburst", axi_arburst, 2'b01);
    check("rst_rready", axi_rready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_hdr_err", hdr_err, 0);
  endtask

  int m0, a0, h0, b0;

  initial begin
    idle_inputs();
    repeat (3) @(negedge axi_aclk);
    reset_checks();
    axi_aresetn = 1'b1;

    // Single 4-beat transfer.
    m0 = m_beats; a0 = ar_seen;
    queue_cmd(32'h0000_1000, 32'd4, 0);
    run_done(200);
    check("basic_beats", 64'(m_beats - m0), 4);
    check("basic_ars", 64'(ar_seen - a0), 1);

    // 600 beats split into three bursts, one bubble at each boundary.
    m0 = m_beats; a0 = ar_seen; first_m = -1;
    queue_cmd(32'h0000_1000, 32'd600, 0);
    run_done(2000);
    check("long_beats", 64'(m_beats - m0), 600);
    check("long_ars", 64'(ar_seen - a0), 3);
    check("long_span", 64'(last_m - first_m), 601);

    // Random backpressure, first with rvalid always high, then with random rvalid.
    p_tr = 50; p_arr = 50; p_cmdv = 70;
    for (int t = 0; t < 5; t++) begin
      p_rv = (t < 2) ? 100 : 60;
      m0 = m_beats;
      if (t == 4) queue_cmd(32'hFFFF_FF00, 32'd100, 0);
      else queue_cmd($urandom() & 32'hFFFF_FFFC, 32'($urandom_range(1, 400)), 0);
      run_done(20000);
      check("rand_all_beats_out", exp_d_q.size(), 0);
    end
    p_tr = 100; p_rv = 100; p_arr = 100; p_cmdv = 100;

    // Zero length: no AR, busy never raised.
    a0 = ar_seen; b0 = busy_seen;
    queue_cmd(32'h0000_2000, 32'd0, 0);
    run_done(100);
    check("zero_len_ars", 64'(ar_seen - a0), 0);
    check("zero_len_busy", 64'(busy_seen - b0), 0);

    // Short header dropped, then a 3-beat header with the extra beat drained.
    a0 = ar_seen; h0 = hdr_err_seen;
    cmd_q.push_back({1'b0, 1'b1, 32'h0000_1234});
    run_done(100);
    check("short_hdr_err", 64'(hdr_err_seen - h0), 1);
    check("short_hdr_ars", 64'(ar_seen - a0), 0);
    m0 = m_beats;
    queue_cmd(32'h0000_3000, 32'd8, 1);
    run_done(200);
    check("drain_ars", 64'(ar_seen - a0), 1);
    check("drain_beats", 64'(m_beats - m0), 8);
    check("drain_no_hdr_err", 64'(hdr_err_seen - h0), 1);

    // Early rlast on one burst.
    check("err_clear_before", err, 0);
    m0 = m_beats; early_burst = burst_no;
    queue_cmd(32'h0000_4000, 32'd4, 0);
    run_done(200);
    check("early_rlast_err", err, 1);
    check("early_rlast_beats", 64'(m_beats - m0), 4);

    // Asynchronous reset in the middle of a data phase.
    m0 = m_beats;
    queue_cmd(32'h0000_8000, 32'd40, 0);
    for (int n = 0; n < 200 && (m_beats - m0) < 5; n++) step();
    check("mid_reset_in_data", sl_act, 1);
    #2;
    axi_aresetn = 1'b0;
    #1;
    reset_checks();
    cmd_q.delete(); exp_ar_q.delete(); exp_d_q.delete();
    sl_act = 0; exp_arv = 0; fin_chk = 0; ar_wait = 0;
    idle_inputs();
    repeat (2) @(negedge axi_aclk);
    axi_aresetn = 1'b1;

    // SLVERR on the second beat after reset; data still forwarded and err sticks.
    m0 = m_beats; slverr_beat = r_beats + 1;
    queue_cmd(32'h0000_5000, 32'd6, 0);
    run_done(200);
    check("slverr_err", err, 1);
    check("slverr_beats", 64'(m_beats - m0), 6);
    queue_cmd(32'h0000_6000, 32'd3, 0);
    run_done(200);
    check("err_sticky", err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
